// File: rtl/snap_capture_pkg.sv
// Shared types for the snapshot capture block: state encoding,
// stored word layout and lane pack/unpack helpers.
package snap_capture_pkg;

    localparam int SNAP_BUS_NUM    = 4;
    localparam int SNAP_DOUT_WIDTH = 16;
    localparam int SNAP_LANE_W     = SNAP_BUS_NUM * SNAP_DOUT_WIDTH;
    localparam int SNAP_WORD_W     = 2 * SNAP_LANE_W;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREFILL   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4,
        ST_READ      = 3'd5
    } snap_state_t;

    typedef logic [SNAP_WORD_W-1:0] snap_word_t;
    typedef logic [SNAP_LANE_W-1:0] snap_lanes_t;

    // Imag lanes sit in the upper half of a stored word.
    function automatic snap_word_t snap_pack(snap_lanes_t re, snap_lanes_t im);
        return {im, re};
    endfunction

    function automatic snap_lanes_t snap_real(snap_word_t w);
        return w[SNAP_LANE_W-1:0];
    endfunction

    function automatic snap_lanes_t snap_imag(snap_word_t w);
        return w[SNAP_WORD_W-1:SNAP_LANE_W];
    endfunction

endpackage

// File: rtl/snap_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Contents are not reset.
module snap_sdp_ram #(
    parameter int  DEPTH = 1024,
    parameter int  WIDTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/snap_capture.sv
// Ring-buffer snapshot of one selected multi-lane complex stream with
// decimation, pre-trigger depth and a valid/ready readout port.
module snap_capture
    import snap_capture_pkg::*;
#(
    parameter int  NUM_SRC    = 3,
    parameter int  BUS_NUM    = SNAP_BUS_NUM,
    parameter int  DOUT_WIDTH = SNAP_DOUT_WIDTH,
    parameter int  DEPTH      = 1024,
    localparam int AW         = $clog2(DEPTH),
    localparam int SW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int LW         = BUS_NUM * DOUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    din_en,
    input  logic [NUM_SRC*LW-1:0] din_real,
    input  logic [NUM_SRC*LW-1:0] din_imag,
    input  logic [SW-1:0]         src_sel,
    input  logic [7:0]            dec_ratio,
    input  logic [AW-1:0]         pre_len,
    input  logic                  arm,
    input  logic                  trig,
    input  logic                  abort,
    input  logic                  rd_start,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [LW-1:0]         dout_real,
    output logic [LW-1:0]         dout_imag,
    output logic                  dout_last,
    output logic [2:0]            state_o,
    output logic                  trig_seen
);

    snap_state_t state;

    logic [SW-1:0] src_q;
    logic [7:0]    dec_q, dec_cnt;
    logic [AW-1:0] pre_q, fill_cnt, wr_ptr, rd_base;
    logic [AW-1:0] rd_ptr, out_cnt, raddr;
    logic [AW:0]   post_cnt, post_init, iss_cnt;
    logic          trig_q, rd_pend, skid_v, out_v;
    snap_word_t    skid_w, out_w, ram_q, wr_word;
    logic [LW-1:0] sel_re, sel_im;
    logic [1:0]    occ;
    logic          en_sel, capturing, dec_wrap, accept;
    logic          pop, last_pop, rd_go, rd_more, ram_re;

    assign en_sel    = (int'(src_q) < NUM_SRC) && din_en[src_q];
    assign sel_re    = din_real[int'(src_q)*LW +: LW];
    assign sel_im    = din_imag[int'(src_q)*LW +: LW];
    assign wr_word   = snap_pack(sel_re, sel_im);
    assign capturing = (state == ST_PREFILL) || (state == ST_WAIT_TRIG) ||
                       (state == ST_POST);
    assign dec_wrap  = (dec_q <= 8'd1) || (dec_cnt >= dec_q - 8'd1);
    assign accept    = capturing && en_sel && (dec_cnt == 8'd0) && !abort;
    assign post_init = (AW+1)'(DEPTH) - {1'b0, pre_q};

    // Two-slot readout pipe (output + skid); a read is issued only when
    // its data is guaranteed a slot one cycle later.
    assign pop      = out_v && dout_ready;
    assign last_pop = pop && (out_cnt == AW'(DEPTH-1));
    assign occ      = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, rd_pend};
    assign rd_go    = (state == ST_DONE) && rd_start && !abort && !arm;
    assign rd_more  = (state == ST_READ) && !abort &&
                      (iss_cnt < (AW+1)'(DEPTH)) &&
                      (pop ? (occ <= 2'd2) : (occ <= 2'd1));
    assign ram_re   = rd_go || rd_more;
    assign raddr    = rd_go ? rd_base : rd_ptr;

    snap_sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(snap_word_t))
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (wr_word),
        .re    (ram_re),
        .raddr (raddr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            src_q    <= '0;
            dec_q    <= 8'd1;
            dec_cnt  <= '0;
            pre_q    <= '0;
            fill_cnt <= '0;
            wr_ptr   <= '0;
            rd_base  <= '0;
            post_cnt <= '0;
            trig_q   <= 1'b0;
        end else begin
            if (capturing && en_sel && !abort)
                dec_cnt <= dec_wrap ? 8'd0 : dec_cnt + 8'd1;
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            src_q    <= src_sel;
                            dec_q    <= (dec_ratio == 8'd0) ? 8'd1 : dec_ratio;
                            pre_q    <= pre_len;
                            wr_ptr   <= '0;
                            dec_cnt  <= '0;
                            fill_cnt <= '0;
                            trig_q   <= 1'b0;
                            state    <= (pre_len == '0) ? ST_WAIT_TRIG : ST_PREFILL;
                        end else if (state == ST_DONE && rd_start) begin
                            state <= ST_READ;
                        end
                    end
                    ST_PREFILL: begin
                        if (accept) begin
                            fill_cnt <= fill_cnt + 1'b1;
                            if (fill_cnt == pre_q - 1'b1)
                                state <= ST_WAIT_TRIG;
                        end
                    end
                    ST_WAIT_TRIG: begin
                        if (trig) begin
                            trig_q <= 1'b1;
                            if (accept && post_init == (AW+1)'(1)) begin
                                state   <= ST_DONE;
                                rd_base <= wr_ptr + 1'b1;
                            end else begin
                                state    <= ST_POST;
                                post_cnt <= accept ? post_init - 1'b1 : post_init;
                            end
                        end
                    end
                    ST_POST: begin
                        if (accept) begin
                            post_cnt <= post_cnt - 1'b1;
                            if (post_cnt == (AW+1)'(1)) begin
                                state   <= ST_DONE;
                                rd_base <= wr_ptr + 1'b1;
                            end
                        end
                    end
                    ST_READ: begin
                        if (last_pop)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_ptr  <= '0;
            iss_cnt <= '0;
            out_cnt <= '0;
            out_v   <= 1'b0;
            out_w   <= '0;
            skid_v  <= 1'b0;
            skid_w  <= '0;
        end else begin
            rd_pend <= ram_re;
            if (rd_go) begin
                rd_ptr  <= rd_base + 1'b1;
                iss_cnt <= (AW+1)'(1);
                out_cnt <= '0;
            end else if (rd_more) begin
                rd_ptr  <= rd_ptr + 1'b1;
                iss_cnt <= iss_cnt + 1'b1;
            end
            if (pop)
                out_cnt <= out_cnt + 1'b1;
            if (abort || last_pop) begin
                out_v  <= 1'b0;
                skid_v <= 1'b0;
            end else if (!out_v || pop) begin
                if (skid_v) begin
                    out_w  <= skid_w;
                    out_v  <= 1'b1;
                    skid_v <= rd_pend;
                    if (rd_pend) skid_w <= ram_q;
                end else if (rd_pend) begin
                    out_w <= ram_q;
                    out_v <= 1'b1;
                end else begin
                    out_v <= 1'b0;
                end
            end else if (rd_pend) begin
                skid_w <= ram_q;
                skid_v <= 1'b1;
            end
        end
    end

    assign dout_valid = out_v;
    assign dout_real  = snap_real(out_w);
    assign dout_imag  = snap_imag(out_w);
    assign dout_last  = out_v && (out_cnt == AW'(DEPTH-1));
    assign state_o    = state;
    assign trig_seen  = trig_q;

endmodule
